uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter slice.
// Holds the FSM encoding and the round-robin pointer helper.
package uart_tx_arbiter_pkg;

    localparam int unsigned DEFAULT_NUM_REQ      = 4;
    localparam int unsigned DEFAULT_IDLE_TIMEOUT = 1024;
    localparam int unsigned BYTE_W               = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        SENT  = 2'd2
    } arb_state_t;

    // Index following idx, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ; returns one-hot grant, its index and a hit flag.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            int unsigned cand;
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!any && req[cand]) begin
                any          = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding bytes from NUM_REQ requesters
// into a single UART transmitter, with a stall timeout on the owner.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int unsigned IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_transmit,
    input  logic                   uart_tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   timeout
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(IDLE_TIMEOUT);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(IDLE_TIMEOUT - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic [7:0]         data_d;
    logic               tx_d;
    logic               timeout_d;

    logic [NUM_REQ-1:0] rr_gnt;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;

    logic               own_fire;
    logic               own_last;
    logic [7:0]         own_data;
    logic [IDX_W-1:0]   owner_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    always_comb begin
        own_fire   = req_valid[owner_q] & req_ready[owner_q];
        own_last   = req_last[owner_q];
        own_data   = req_data[32'(owner_q)*BYTE_W +: BYTE_W];
        owner_next = IDX_W'(wrap_inc(32'(owner_q), NUM_REQ));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= IDLE;
            grant            <= '0;
            owner_q          <= '0;
            ptr_q            <= '0;
            cnt_q            <= '0;
            last_q           <= 1'b0;
            uart_tx_data     <= '0;
            uart_tx_transmit <= 1'b0;
            timeout          <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant            <= grant_d;
            owner_q          <= owner_d;
            ptr_q            <= ptr_d;
            cnt_q            <= cnt_d;
            last_q           <= last_d;
            uart_tx_data     <= data_d;
            uart_tx_transmit <= tx_d;
            timeout          <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        data_d    = uart_tx_data;
        tx_d      = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_gnt;
                    owner_d = rr_idx;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Stalls only count while the UART could accept a byte.
                if (own_fire) begin
                    data_d  = own_data;
                    tx_d    = 1'b1;
                    last_d  = own_last;
                    cnt_d   = '0;
                    state_d = SENT;
                end else if (uart_tx_ready) begin
                    if (cnt_q == STALL_MAX) begin
                        grant_d   = '0;
                        ptr_d     = owner_next;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SENT: begin
                // The UART dropping ready is the acknowledge of our byte.
                if (!uart_tx_ready) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = owner_next;
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == ISSUE && uart_tx_ready) begin
            req_ready = grant;
        end
    end

endmodule
